updown_mod_counter: RTL
=======================

Name: updown_mod_counter

Overview:
Parametrised successor to the team's 8-bit enable/load counter. Provides:
- up/down counting with a programmable modulus;
- wrap or saturate mode;
- synchronous clear and parallel load with defined priority;
- a registered boundary-event pulse and a sticky event flag;
- a per-bit output-enable vector for driving a bidirectional pad bank.

It sits behind the Tiny Tapeout top-level wrapper, which maps its ports onto ui_in, uio_in, uo_out and uio_oe.

Parameters:
- WIDTH, 8, counter width in bits (2..32).
- MAX_VALUE, 2**WIDTH-1, highest legal count. Must be less than 2**WIDTH. The counter range is 0..MAX_VALUE.
- RESET_VALUE, 0, count value after reset or clr. Must be less than or equal to MAX_VALUE.
- PRESCALE, 4, enabled cycles per step (2..256). Used only when CNT_PRESCALE_EN is defined.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear to RESET_VALUE; also clears evt_sticky.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value to load.
- en  in  1  count enable.
- dir  in  1  count direction: 1 = up, 0 = down.
- sat_mode  in  1  boundary mode: 1 = saturate, 0 = wrap.
- oe  in  1  output enable request.
- count  out  WIDTH  current count (registered).
- count_oe  out  WIDTH  per-bit drive enable, equal to {WIDTH{oe}} (combinational).
- evt  out  1  one-cycle registered boundary pulse.
- evt_sticky  out  1  sticky boundary flag.

Behaviour:
- Reset is decided as: rst_n, asynchronous, active-low; clock clk.
- While rst_n is low: count = RESET_VALUE, evt = 0, evt_sticky = 0, prescaler = 0. count_oe still follows oe.
- All state updates happen on the rising edge of clk. count reflects an action on the edge where it is sampled, so latency is 1 cycle.
- Priority per edge: clr > load > en step > hold.
- clr: count <= RESET_VALUE, evt <= 0, evt_sticky <= 0, prescaler cleared.
- load: count <= min(load_val, MAX_VALUE), so out-of-range values clamp. evt <= 0. Prescaler cleared.
- en step, up direction (dir = 1):
  - count < MAX_VALUE: count + 1.
  - count == MAX_VALUE, wrap mode: count <= 0.
  - count == MAX_VALUE, saturate mode: count holds.
- en step, down direction (dir = 0):
  - count > 0: count - 1.
  - count == 0, wrap mode: count <= MAX_VALUE.
  - count == 0, saturate mode: count holds.
- Boundary event: a step attempted at a boundary (MAX_VALUE going up, or 0 going down), in either mode.
  - evt is 1 in the cycle after that edge and 0 otherwise; it never stretches across cycles.
  - evt_sticky <= 1 on a boundary event and stays set until clr or reset.
- Idle: en = 0 with no clr or load means count, evt_sticky and prescaler hold, and evt <= 0.
- dir and sat_mode may change on any cycle. Only their values at the stepping edge matter.
- Arithmetic is done at WIDTH+1 bits or via explicit compare. No implicit overflow is allowed when MAX_VALUE = 2**WIDTH-1.
- Reset asserted mid-operation overrides everything asynchronously. After rst_n rises, the first edge behaves as from reset.
- count_oe is purely combinational from oe. The wrapper uses it for tri-state, so there is no internal tri-state logic.

Optional Feature:
CNT_PRESCALE_EN.
- Defined: an internal counter of ceil(log2(PRESCALE)) bits advances on each en cycle that has no clr or load.
  - A step, and any boundary event, occurs only on the en cycle where the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - The prescaler holds when en = 0. clr and load reset it.
- Undefined: no prescaler; every en cycle steps, and the PRESCALE parameter is ignored.

Decomposition:
- Package counter_pkg holds:
  - DIR_UP = 1'b1, DIR_DOWN = 1'b0;
  - MODE_WRAP = 1'b0, MODE_SAT = 1'b1;
  - a function clamp_load(value, max).
- One sub-module, cnt_prescaler (parameter PRESCALE; ports clk, rst_n, clr, en, tick).
  - It is instantiated only under CNT_PRESCALE_EN.
  - Otherwise tick = en.

Test Plan:
Benches use WIDTH = 8 and MAX_VALUE = 9 unless stated otherwise.
- Reset and load: hold rst_n = 0 for 3 cycles, release, then load with load_val = 5 → count = 0 and evt_sticky = 0 during reset; count = 5 one cycle after load; load_val = 200 → count = 9 (clamped).
- Wrap up: count = 8, en = 1, dir = 1, sat_mode = 0, for 3 cycles → count = 9, 0, 1; evt high only in the cycle count shows 0; evt_sticky = 1 afterwards.
- Saturate down: count = 1, en = 1, dir = 0, sat_mode = 1, for 4 cycles → count = 0, 0, 0, 0; evt high for each of the 3 cycles following the blocked steps; clr → count = 0, evt_sticky = 0.
- Priority: clr, load (load_val = 7) and en all high in the same cycle → count = RESET_VALUE; then load and en high together → count = 7, not 8.
- Full range: WIDTH = 8, MAX_VALUE = 255, count = 255, step up in wrap mode → count = 0 and evt = 1; step down from 0 → count = 255.
- With CNT_PRESCALE_EN and PRESCALE = 4: from count = 0, en = 1 for 8 cycles → count increments on the 4th and 8th cycles only, ending at 2. Toggle oe → count_oe = 8'hFF / 8'h00 in the same cycle.

Source files
------------

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared constants and helpers for the up/down modulus
//                counter and its prescaler.
//                - DIR_UP / DIR_DOWN   : encodings of the dir input
//                - MODE_WRAP / MODE_SAT: encodings of the sat_mode input
//                - clamp_load()        : limits a load value to the legal
//                                        count range
//  Revision    : 1.0  initial release
// ============================================================================
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Values above the modulus clamp to the modulus. Operates at 32 bits,
  // which covers every legal counter width.
  function automatic logic [31:0] clamp_load(input logic [31:0] value,
                                             input logic [31:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage : counter_pkg
`default_nettype wire

// File: rtl/cnt_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_prescaler
//  Description : Divides enabled cycles by PRESCALE. tick is high on the
//                enabled cycle where the internal count reaches PRESCALE-1;
//                the count then returns to 0. Holds while en is low.
//  Ports       : clk   in  clock
//                rst_n in  asynchronous active-low reset
//                clr   in  synchronous clear (clear or load in the parent)
//                en    in  count enable
//                tick  out one step request (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module cnt_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int              PW   = $clog2(PRESCALE);
  localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]   ONE  = PW'(1);

  logic [PW-1:0] cnt;
  logic          at_last;

  assign at_last = (cnt == LAST);
  // clr wins over a pending tick so a clear/load cycle never steps.
  assign tick    = en & ~clr & at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_last ? '0 : cnt + ONE;
    end
  end

endmodule : cnt_prescaler
`default_nettype wire

// File: rtl/updown_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : updown_mod_counter
//  Description : Up/down counter over 0..MAX_VALUE with wrap or saturate
//                at the boundaries, synchronous clear and clamped parallel
//                load (clr > load > step > hold), a registered one-cycle
//                boundary pulse, a sticky boundary flag and a per-bit
//                output-enable vector for a bidirectional pad bank.
//  Ports       : clk        in  clock
//                rst_n      in  asynchronous active-low reset
//                clr        in  clear to RESET_VALUE, clears evt_sticky
//                load       in  parallel load of min(load_val, MAX_VALUE)
//                load_val   in  [WIDTH] load value
//                en         in  count enable
//                dir        in  1 = up, 0 = down
//                sat_mode   in  1 = saturate, 0 = wrap
//                oe         in  output enable request
//                count      out [WIDTH] registered count
//                count_oe   out [WIDTH] {WIDTH{oe}}, combinational
//                evt        out one-cycle boundary pulse
//                evt_sticky out sticky boundary flag
//  Options     : CNT_PRESCALE_EN - when defined, a step happens only every
//                PRESCALE enabled cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH       = 8,
  parameter longint unsigned MAX_VALUE   = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned RESET_VALUE = 64'd0,
  parameter int              PRESCALE    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  input  logic             sat_mode,
  input  logic             oe,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_oe,
  output logic             evt,
  output logic             evt_sticky
);

  localparam logic [WIDTH-1:0] MAX_C   = MAX_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RESET_C = RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic             tick;
  logic [31:0]      clamp_wide;
  logic [WIDTH-1:0] load_clamped;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] count_nxt;
  logic             evt_nxt;
  logic             sticky_nxt;

  // ---------------------------------------------------------------------
  // Step request source
  // ---------------------------------------------------------------------
`ifdef CNT_PRESCALE_EN
  // Clear and load both restart the prescaler.
  cnt_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr | load),
    .en    (en),
    .tick  (tick)
  );
`else
  localparam int unused_prescale = PRESCALE;
  assign tick = en;
`endif

  // ---------------------------------------------------------------------
  // Load clamping
  // ---------------------------------------------------------------------
  assign clamp_wide   = clamp_load(32'(load_val), 32'(MAX_VALUE));
  assign load_clamped = clamp_wide[WIDTH-1:0];

  generate
    if (WIDTH < 32) begin : g_clamp_hi
      // Upper bits are always zero once clamped to a WIDTH-bit modulus.
      logic unused_clamp_hi;
      assign unused_clamp_hi = |clamp_wide[31:WIDTH];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Next-state logic. Boundaries are found by explicit compare, so the
  // +1 / -1 paths never overflow even when MAX_VALUE is all ones.
  // ---------------------------------------------------------------------
  assign at_max  = (count == MAX_C);
  assign at_zero = (count == '0);

  always_comb begin
    count_nxt  = count;
    evt_nxt    = 1'b0;
    sticky_nxt = evt_sticky;
    if (clr) begin
      count_nxt  = RESET_C;
      sticky_nxt = 1'b0;
    end else if (load) begin
      count_nxt = load_clamped;
    end else if (tick) begin
      if (dir == DIR_UP) begin
        if (at_max) begin
          evt_nxt    = 1'b1;
          sticky_nxt = 1'b1;
          if (sat_mode == MODE_WRAP) count_nxt = '0;
        end else begin
          count_nxt = count + ONE;
        end
      end else begin
        if (at_zero) begin
          evt_nxt    = 1'b1;
          sticky_nxt = 1'b1;
          if (sat_mode == MODE_WRAP) count_nxt = MAX_C;
        end else begin
          count_nxt = count - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= RESET_C;
      evt        <= 1'b0;
      evt_sticky <= 1'b0;
    end else begin
      count      <= count_nxt;
      evt        <= evt_nxt;
      evt_sticky <= sticky_nxt;
    end
  end

  // Pad drive enables; the tri-state buffers live in the wrapper.
  assign count_oe = {WIDTH{oe}};

endmodule : updown_mod_counter
`default_nettype wire
